// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM state codes,
// opcodes, datapath mux selects, immediate formats and ALU operation codes.
package riscv_ctrl_pkg;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECR    = 4'd6;
   localparam logic [3:0] S_EXECI    = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_JAL      = 4'd9;
   localparam logic [3:0] S_BRANCH   = 4'd10;
   localparam logic [3:0] S_LUI      = 4'd11;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [1:0] SRC_A_PC    = 2'b00;
   localparam logic [1:0] SRC_A_OLDPC = 2'b01;
   localparam logic [1:0] SRC_A_RS1   = 2'b10;

   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_IMM  = 2'b01;
   localparam logic [1:0] SRC_B_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;
   localparam logic [1:0] RES_IMMEXT    = 2'b11;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Codes are 4 bits wide; narrower builds simply never produce SRA/SLTU.
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLL  = 4'b0110;
   localparam logic [3:0] ALU_SRL  = 4'b0111;
   localparam logic [3:0] ALU_SRA  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   typedef enum logic [1:0] {
      ALU_OP_ADD   = 2'b00,
      ALU_OP_SUB   = 2'b01,
      ALU_OP_FUNCT = 2'b10
   } alu_op_t;

   function automatic logic [2:0] imm_src_of(input logic [6:0] op);
      case (op)
         OP_STORE:  return IMM_S;
         OP_BRANCH: return IMM_B;
         OP_JAL:    return IMM_J;
         OP_LUI:    return IMM_U;
         default:   return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU control decoder: maps alu_op/funct3/funct7_5 to an ALU operation code,
// zero-extended to ALU_CTRL_W bits. Widths of 4+ unlock SRA and SLTU.
module alu_decoder
   import riscv_ctrl_pkg::*;
#(
   parameter int ALU_CTRL_W = 3
) (
   input  alu_op_t               alu_op,
   input  logic [2:0]            funct3,
   input  logic                  op_5,
   input  logic                  funct7_5,
   output logic [ALU_CTRL_W-1:0] alu_control
);

   localparam bit WIDE = (ALU_CTRL_W >= 4);

   logic [3:0] code;

   always_comb begin
      code = ALU_ADD;
      case (alu_op)
         ALU_OP_SUB: code = ALU_SUB;
         ALU_OP_FUNCT: begin
            case (funct3)
               3'b000:  code = (op_5 && funct7_5) ? ALU_SUB : ALU_ADD;
               3'b001:  code = ALU_SLL;
               3'b010:  code = ALU_SLT;
               3'b011:  code = WIDE ? ALU_SLTU : ALU_SLT;
               3'b100:  code = ALU_XOR;
               3'b101:  code = (WIDE && funct7_5) ? ALU_SRA : ALU_SRL;
               3'b110:  code = ALU_OR;
               default: code = ALU_AND;
            endcase
         end
         default: code = ALU_ADD;
      endcase
   end

   assign alu_control = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM control unit for the multicycle RV32I core with memory stall handshake.
// Define BRANCH_EXT_EN to add bne/blt/bge/bltu/bgeu; otherwise only beq is legal.
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter int ALU_CTRL_W = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [6:0]            op,
   input  logic [2:0]            funct3,
   input  logic                  funct7_5,
   input  logic                  zero,
   input  logic                  negative,
   input  logic                  carry,
   input  logic                  overflow,
   input  logic                  mem_ready,
   output logic                  pc_write,
   output logic                  adr_src,
   output logic                  ir_write,
   output logic                  mem_write,
   output logic                  reg_write,
   output logic [1:0]            alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic [1:0]            result_src,
   output logic [2:0]            imm_src,
   output logic [ALU_CTRL_W-1:0] alu_control,
   output logic                  illegal_instr
);

   logic [3:0] state;
   logic [3:0] next_state;
   logic [3:0] cur_state;
   logic       pc_w;
   logic       ir_w;
   logic       mem_w;
   logic       reg_w;
   logic       illegal;
   logic       take;
   logic       br_legal;
   alu_op_t    alu_op;

   // While reset is held the outputs look like FETCH, whatever state is stored.
   assign cur_state = reset ? S_FETCH : state;

   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= next_state;
   end

`ifdef BRANCH_EXT_EN
   always_comb begin
      take     = 1'b0;
      br_legal = 1'b1;
      case (funct3)
         F3_BEQ:  take = zero;
         F3_BNE:  take = !zero;
         F3_BLT:  take = negative ^ overflow;
         F3_BGE:  take = !(negative ^ overflow);
         F3_BLTU: take = !carry;
         F3_BGEU: take = carry;
         default: br_legal = 1'b0;
      endcase
   end
`else
   logic unused_flags;
   assign unused_flags = ^{negative, carry, overflow};

   always_comb begin
      br_legal = (funct3 == F3_BEQ);
      take     = br_legal && zero;
   end
`endif

   always_comb begin
      next_state = cur_state;
      pc_w       = 1'b0;
      adr_src    = 1'b0;
      ir_w       = 1'b0;
      mem_w      = 1'b0;
      reg_w      = 1'b0;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_RS2;
      result_src = RES_ALUOUT;
      alu_op     = ALU_OP_ADD;
      illegal    = 1'b0;
      case (cur_state)
         S_FETCH: begin
            alu_src_b  = SRC_B_FOUR;
            result_src = RES_ALURESULT;
            if (mem_ready) begin
               ir_w       = 1'b1;
               pc_w       = 1'b1;
               next_state = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_a = SRC_A_OLDPC;
            alu_src_b = SRC_B_IMM;
            case (op)
               OP_LOAD, OP_STORE: next_state = S_MEMADR;
               OP_RTYPE:          next_state = S_EXECR;
               OP_ITYPE:          next_state = S_EXECI;
               OP_JAL:            next_state = S_JAL;
               OP_BRANCH:         next_state = S_BRANCH;
               OP_LUI:            next_state = S_LUI;
               default: begin
                  next_state = S_FETCH;
                  illegal    = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a  = SRC_A_RS1;
            alu_src_b  = SRC_B_IMM;
            next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            if (mem_ready) next_state = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_w      = 1'b1;
            next_state = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src = 1'b1;
            mem_w   = 1'b1;
            if (mem_ready) next_state = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a  = SRC_A_RS1;
            alu_op     = ALU_OP_FUNCT;
            next_state = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a  = SRC_A_RS1;
            alu_src_b  = SRC_B_IMM;
            alu_op     = ALU_OP_FUNCT;
            next_state = S_ALUWB;
         end
         S_ALUWB: begin
            reg_w      = 1'b1;
            next_state = S_FETCH;
         end
         S_JAL: begin
            alu_src_a  = SRC_A_OLDPC;
            alu_src_b  = SRC_B_FOUR;
            pc_w       = 1'b1;
            next_state = S_ALUWB;
         end
         S_BRANCH: begin
            alu_src_a  = SRC_A_RS1;
            alu_op     = ALU_OP_SUB;
            pc_w       = take;
            illegal    = !br_legal;
            next_state = S_FETCH;
         end
         S_LUI: begin
            result_src = RES_IMMEXT;
            reg_w      = 1'b1;
            next_state = S_FETCH;
         end
         default: next_state = S_FETCH;
      endcase
   end

   assign pc_write      = pc_w & ~reset;
   assign ir_write      = ir_w & ~reset;
   assign mem_write     = mem_w & ~reset;
   assign reg_write     = reg_w & ~reset;
   assign illegal_instr = illegal & ~reset;
   assign imm_src       = imm_src_of(op);

   alu_decoder #(
      .ALU_CTRL_W(ALU_CTRL_W)
   ) u_alu_decoder (
      .alu_op     (alu_op),
      .funct3     (funct3),
      .op_5       (op[5]),
      .funct7_5   (funct7_5),
      .alu_control(alu_control)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: instruction table, stall/reset
// sequences and randomized traffic against a phase-plan reference model.
module tb_multicycle_controller;

   typedef enum int {
      P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
      P_EXECR, P_EXECI, P_ALUWB, P_JAL, P_BRANCH, P_LUI
   } phase_t;

   typedef phase_t plan_t[$];

   typedef struct packed {
      logic       pc_write;
      logic       adr_src;
      logic       ir_write;
      logic       mem_write;
      logic       reg_write;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic [2:0] imm_src;
      logic [3:0] alu_control;
      logic       illegal;
   } out_t;

   typedef struct {
      string      name;
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic       z;
      logic       n;
      logic       c;
      logic       v;
      int         cyc;
      int         regw;
      int         pcw;
      int         memw;
      int         ill;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7_5;
   logic       zero, negative, carry, overflow;
   logic       mem_ready;

   logic       pc_write4, adr_src4, ir_write4, mem_write4, reg_write4, illegal4;
   logic [1:0] alu_src_a4, alu_src_b4, result_src4;
   logic [2:0] imm_src4;
   logic [3:0] alu_control4;
   logic       pc_write3, adr_src3, ir_write3, mem_write3, reg_write3, illegal3;
   logic [1:0] alu_src_a3, alu_src_b3, result_src3;
   logic [2:0] imm_src3;
   logic [2:0] alu_control3;

   int     checks = 0;
   int     failures = 0;
   phase_t phase = P_FETCH;
   plan_t  plan;
   out_t   got4, got3;
   vec_t   vecs[$];

   always #5 clk = ~clk;

   multicycle_controller #(.ALU_CTRL_W(4)) dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7_5(funct7_5),
      .zero(zero), .negative(negative), .carry(carry), .overflow(overflow),
      .mem_ready(mem_ready), .pc_write(pc_write4), .adr_src(adr_src4),
      .ir_write(ir_write4), .mem_write(mem_write4), .reg_write(reg_write4),
      .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .result_src(result_src4),
      .imm_src(imm_src4), .alu_control(alu_control4), .illegal_instr(illegal4)
   );

   multicycle_controller #(.ALU_CTRL_W(3)) dut3 (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7_5(funct7_5),
      .zero(zero), .negative(negative), .carry(carry), .overflow(overflow),
      .mem_ready(mem_ready), .pc_write(pc_write3), .adr_src(adr_src3),
      .ir_write(ir_write3), .mem_write(mem_write3), .reg_write(reg_write3),
      .alu_src_a(alu_src_a3), .alu_src_b(alu_src_b3), .result_src(result_src3),
      .imm_src(imm_src3), .alu_control(alu_control3), .illegal_instr(illegal3)
   );

   // Each opcode expands to the list of phases it walks through after FETCH.
   function automatic plan_t path_of(input logic [6:0] o);
      case (o)
         7'b0000011: return '{P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB};
         7'b0100011: return '{P_DECODE, P_MEMADR, P_MEMWRITE};
         7'b0110011: return '{P_DECODE, P_EXECR, P_ALUWB};
         7'b0010011: return '{P_DECODE, P_EXECI, P_ALUWB};
         7'b1101111: return '{P_DECODE, P_JAL, P_ALUWB};
         7'b1100011: return '{P_DECODE, P_BRANCH};
         7'b0110111: return '{P_DECODE, P_LUI};
         default:    return '{P_DECODE};
      endcase
   endfunction

   function automatic logic [2:0] imm_expect(input logic [6:0] o);
      case (o)
         7'b0100011: return 3'd1;
         7'b1100011: return 3'd2;
         7'b1101111: return 3'd3;
         7'b0110111: return 3'd4;
         default:    return 3'd0;
      endcase
   endfunction

   function automatic logic [3:0] alu_expect(input phase_t p, input int w);
      if (p == P_BRANCH) return 4'd1;
      if (p != P_EXECR && p != P_EXECI) return 4'd0;
      case (funct3)
         3'd0:    return (op[5] && funct7_5) ? 4'd1 : 4'd0;
         3'd1:    return 4'd6;
         3'd2:    return 4'd5;
         3'd3:    return (w >= 4) ? 4'd9 : 4'd5;
         3'd4:    return 4'd4;
         3'd5:    return (funct7_5 && w >= 4) ? 4'd8 : 4'd7;
         3'd6:    return 4'd3;
         default: return 4'd2;
      endcase
   endfunction

   function automatic void branch_rule(output logic legal, output logic tk);
      legal = 1'b1;
      tk    = 1'b0;
      case (funct3)
         3'd0: tk = zero;
`ifdef BRANCH_EXT_EN
         3'd1: tk = !zero;
         3'd4: tk = negative ^ overflow;
         3'd5: tk = !(negative ^ overflow);
         3'd6: tk = !carry;
         3'd7: tk = carry;
`endif
         default: legal = 1'b0;
      endcase
   endfunction

   function automatic out_t expected(input int w);
      out_t   e;
      phase_t p;
      logic   legal, tk;
      plan_t  pl;
      p = reset ? P_FETCH : phase;
      e = '0;
      e.imm_src = imm_expect(op);
      e.alu_control = alu_expect(p, w);
      case (p)
         P_FETCH: begin
            e.alu_src_b = 2'd2; e.result_src = 2'd2;
            if (mem_ready && !reset) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
         end
         P_DECODE: begin
            e.alu_src_a = 2'd1; e.alu_src_b = 2'd1;
            pl = path_of(op);
            e.illegal = (pl.size() == 1);
         end
         P_MEMADR:   begin e.alu_src_a = 2'd2; e.alu_src_b = 2'd1; end
         P_MEMREAD:  e.adr_src = 1'b1;
         P_MEMWB:    begin e.result_src = 2'd1; e.reg_write = 1'b1; end
         P_MEMWRITE: begin e.adr_src = 1'b1; e.mem_write = 1'b1; end
         P_EXECR:    e.alu_src_a = 2'd2;
         P_EXECI:    begin e.alu_src_a = 2'd2; e.alu_src_b = 2'd1; end
         P_ALUWB:    e.reg_write = 1'b1;
         P_JAL:      begin e.alu_src_a = 2'd1; e.alu_src_b = 2'd2; e.pc_write = 1'b1; end
         P_BRANCH: begin
            e.alu_src_a = 2'd2;
            branch_rule(legal, tk);
            e.pc_write = tk;
            e.illegal = !legal;
         end
         default: begin e.result_src = 2'd3; e.reg_write = 1'b1; end
      endcase
      return e;
   endfunction

   task automatic check_val(input string name, input int actual, input int required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
      end
   endtask

   task automatic sample_check();
      out_t   e4, e3;
      phase_t p;
      #1;
      p = reset ? P_FETCH : phase;
      got4 = {pc_write4, adr_src4, ir_write4, mem_write4, reg_write4, alu_src_a4,
              alu_src_b4, result_src4, imm_src4, alu_control4, illegal4};
      got3 = {pc_write3, adr_src3, ir_write3, mem_write3, reg_write3, alu_src_a3,
              alu_src_b3, result_src3, imm_src3, {1'b0, alu_control3}, illegal3};
      e4 = expected(4);
      e3 = expected(3);
      checks += 2;
      if (got4 !== e4) begin
         failures++;
         $display("[TB] FAIL outputs_w4_%s actual=%h required=%h", p.name(), got4, e4);
      end
      if (got3 !== e3) begin
         failures++;
         $display("[TB] FAIL outputs_w3_%s actual=%h required=%h", p.name(), got3, e3);
      end
   endtask

   task automatic advance();
      @(posedge clk);
      if (reset) begin
         phase = P_FETCH;
         plan.delete();
      end else if (!((phase == P_FETCH || phase == P_MEMREAD || phase == P_MEMWRITE) && !mem_ready)) begin
         if (phase == P_FETCH) plan = path_of(op);
         if (plan.size() == 0) phase = P_FETCH;
         else phase = plan.pop_front();
      end
      @(negedge clk);
   endtask

   // Runs one instruction from FETCH until the DUT fetches again; mem_ready is
   // pulled low for lo_len cycles starting at cycle index lo_start.
   task automatic run_instr(input string name, input int lo_start, input int lo_len,
                            output int n, output int regw, output int pcw,
                            output int memw, output int ill, output int adr_cyc);
      n = 0; regw = 0; pcw = 0; memw = 0; ill = 0; adr_cyc = 0;
      for (int k = 0; k < 20; k++) begin
         mem_ready = !(k >= lo_start && k < lo_start + lo_len);
         sample_check();
         if (k > 0 && got4.ir_write) begin
            n = k;
            return;
         end
         regw    += int'(got4.reg_write);
         pcw     += int'(got4.pc_write);
         memw    += int'(got4.mem_write);
         ill     += int'(got4.illegal);
         adr_cyc += int'(got4.adr_src && !got4.mem_write);
         advance();
      end
      n = 20;
      checks++;
      failures++;
      $display("[TB] FAIL timeout_%s actual=no_refetch required=refetch_within_20", name);
   endtask

   task automatic applyStimulus();
      int n, regw, pcw, memw, ill, adr_cyc;
      logic [6:0] ops[8];
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
              7'b1101111, 7'b1100011, 7'b0110111, 7'b0000000};

      vecs.push_back('{"add",    7'b0110011, 3'd0, 1'b0, 0, 0, 0, 0, 4, 1, 1, 0, 0});
      vecs.push_back('{"sub",    7'b0110011, 3'd0, 1'b1, 0, 0, 0, 0, 4, 1, 1, 0, 0});
      vecs.push_back('{"srai",   7'b0010011, 3'd5, 1'b1, 0, 0, 0, 0, 4, 1, 1, 0, 0});
      vecs.push_back('{"sltu",   7'b0110011, 3'd3, 1'b0, 0, 0, 0, 0, 4, 1, 1, 0, 0});
      vecs.push_back('{"lw",     7'b0000011, 3'd2, 1'b0, 0, 0, 0, 0, 5, 1, 1, 0, 0});
      vecs.push_back('{"sw",     7'b0100011, 3'd2, 1'b0, 0, 0, 0, 0, 4, 0, 1, 1, 0});
      vecs.push_back('{"beq_t",  7'b1100011, 3'd0, 1'b0, 1, 0, 0, 0, 3, 0, 2, 0, 0});
      vecs.push_back('{"beq_nt", 7'b1100011, 3'd0, 1'b0, 0, 0, 0, 0, 3, 0, 1, 0, 0});
      vecs.push_back('{"jal",    7'b1101111, 3'd0, 1'b0, 0, 0, 0, 0, 4, 1, 2, 0, 0});
      vecs.push_back('{"lui",    7'b0110111, 3'd0, 1'b0, 0, 0, 0, 0, 3, 1, 1, 0, 0});
      vecs.push_back('{"badop",  7'b1111111, 3'd0, 1'b0, 0, 0, 0, 0, 2, 0, 1, 0, 1});
      vecs.push_back('{"br_010", 7'b1100011, 3'd2, 1'b0, 1, 0, 0, 0, 3, 0, 1, 0, 1});
`ifdef BRANCH_EXT_EN
      vecs.push_back('{"blt",    7'b1100011, 3'd4, 1'b0, 0, 1, 0, 0, 3, 0, 2, 0, 0});
      vecs.push_back('{"bgeu",   7'b1100011, 3'd7, 1'b0, 0, 0, 1, 0, 3, 0, 2, 0, 0});
      vecs.push_back('{"bne",    7'b1100011, 3'd1, 1'b0, 1, 0, 0, 0, 3, 0, 1, 0, 0});
`else
      vecs.push_back('{"blt",    7'b1100011, 3'd4, 1'b0, 0, 1, 0, 0, 3, 0, 1, 0, 1});
      vecs.push_back('{"bne",    7'b1100011, 3'd1, 1'b0, 0, 0, 0, 0, 3, 0, 1, 0, 1});
`endif

      reset = 1'b1; op = '0; funct3 = '0; funct7_5 = 1'b0;
      zero = 1'b0; negative = 1'b0; carry = 1'b0; overflow = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      sample_check();
      check_val("reset_no_pc_write", int'(got4.pc_write), 0);
      advance();
      sample_check();
      advance();
      reset = 1'b0;

      foreach (vecs[i]) begin
         op = vecs[i].op; funct3 = vecs[i].f3; funct7_5 = vecs[i].f7;
         zero = vecs[i].z; negative = vecs[i].n; carry = vecs[i].c; overflow = vecs[i].v;
         run_instr(vecs[i].name, 99, 0, n, regw, pcw, memw, ill, adr_cyc);
         check_val({vecs[i].name, "_cycles"}, n, vecs[i].cyc);
         check_val({vecs[i].name, "_reg_write"}, regw, vecs[i].regw);
         check_val({vecs[i].name, "_pc_write"}, pcw, vecs[i].pcw);
         check_val({vecs[i].name, "_mem_write"}, memw, vecs[i].memw);
         check_val({vecs[i].name, "_illegal"}, ill, vecs[i].ill);
      end

      op = 7'b0000011; funct3 = 3'd2; funct7_5 = 1'b0;
      run_instr("lw_stall", 3, 3, n, regw, pcw, memw, ill, adr_cyc);
      check_val("lw_stall_cycles", n, 8);
      check_val("lw_stall_memread_cycles", adr_cyc, 4);
      check_val("lw_stall_reg_write", regw, 1);

      op = 7'b0100011;
      for (int k = 0; k < 4; k++) begin
         mem_ready = (k < 2);
         sample_check();
         advance();
      end
      mem_ready = 1'b0;
      sample_check();
      check_val("sw_mem_write_held", int'(got4.mem_write), 1);
      advance();
      reset = 1'b1;
      sample_check();
      check_val("reset_mid_memwrite_mem_write", int'(got4.mem_write), 0);
      check_val("reset_mid_memwrite_reg_write", int'(got4.reg_write), 0);
      check_val("reset_mid_memwrite_alu_src_b", int'(got4.alu_src_b), 2);
      advance();
      reset = 1'b0;
      mem_ready = 1'b1;
      sample_check();
      check_val("fetch_after_reset_ir_write", int'(got4.ir_write), 1);

      for (int k = 0; k < 800; k++) begin
         if (phase == P_FETCH) begin
            op = ops[$urandom_range(0, 7)];
            if (op == 7'b0000000) op = 7'($urandom);
            funct3 = 3'($urandom);
            funct7_5 = 1'($urandom);
         end
         zero = 1'($urandom); negative = 1'($urandom);
         carry = 1'($urandom); overflow = 1'($urandom);
         mem_ready = ($urandom_range(0, 9) < 7);
         reset = ($urandom_range(0, 59) == 0);
         sample_check();
         advance();
      end
      reset = 1'b0;
   endtask

   task automatic checkOutput();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
   endtask

   initial begin
      applyStimulus();
      checkOutput();
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multicycle RV32I core; successor to the single-cycle controller.
- Moore FSM sequences fetch, decode, execute, memory and writeback across several cycles, sharing one ALU and one memory port.
- Adds a memory-ready stall handshake, I-type/LUI support, parametrised ALU-control width and illegal-opcode flagging.
- Sits between the instruction register, datapath flags and the datapath muxes/enables.

Parameters:
- ALU_CTRL_W, 3, alu_control width. 3 gives the base encoding; 4 adds sra=1000 and sltu=1001.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous active-high reset
- op  in  7  instruction opcode from IR
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- zero, negative, carry, overflow  in  1 each  ALU flags
- mem_ready  in  1  memory completes the access this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut
- ir_write  out  1  IR/OldPC enable
- mem_write  out  1  data memory write strobe
- reg_write  out  1  register file write
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1
- alu_src_b  out  2  00=rs2, 01=ImmExt, 10=const 4
- result_src  out  2  00=ALUOut, 01=Data, 10=ALUResult, 11=ImmExt
- imm_src  out  3  000=I, 001=S, 010=B, 011=J, 100=U
- alu_control  out  ALU_CTRL_W  ALU operation
- illegal_instr  out  1  unsupported opcode (or branch funct3)

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset effect: state<=FETCH. While reset is high, pc_write, ir_write, mem_write, reg_write and illegal_instr are 0. All other outputs carry the FETCH values. Reset mid-instruction abandons the instruction with no writes.
- Outputs are combinational from state plus inputs. Unlisted outputs are 0; alu_op defaults to 00.
- FETCH:
  - Drives adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - If mem_ready: ir_write=1, pc_write=1, go to DECODE.
  - Else hold in FETCH with both enables 0.
- DECODE:
  - Drives alu_src_a=01, alu_src_b=01, alu_op=00 (computes the branch target).
  - Next state by opcode:
    - 0000011/0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 1100011 -> BRANCH
    - 0110111 -> LUI
    - any other opcode -> FETCH with illegal_instr=1 for this cycle
- MEMADR: alu_src_a=10, alu_src_b=01. Goes to MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Stalls until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1 held each cycle until mem_ready, then FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, then ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- JAL: alu_src_a=01, alu_src_b=10, result_src=00, pc_write=1, then ALUWB.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=take, then FETCH.
  - take = zero for beq (funct3 000).
  - Other funct3 values set illegal_instr=1 and take=0.
- LUI: result_src=11, reg_write=1, then FETCH.
- imm_src decode from op: I-type=000, S=001, B=010, J=011, U=100; otherwise 000.
- ALU decode:
  - alu_op 00 -> add (000); alu_op 01 -> sub (001).
  - alu_op 10 decodes funct3:
    - 000: sub if op[5]&funct7_5, else add
    - 010: slt (101)
    - 100: xor (100)
    - 110: or (011)
    - 111: and (010)
    - 001: sll (110)
    - 101: srl (111), or sra (1000) when funct7_5=1 and ALU_CTRL_W>=4
    - 011: sltu (1001) when ALU_CTRL_W>=4, else slt
- Width rule: all codes zero-extended to ALU_CTRL_W.
- Latencies with mem_ready tied high: R/I/JAL 4 cycles, lw 5, sw 4, beq 3, LUI 3.

Optional Feature:
- Macro BRANCH_EXT_EN enables bne/blt/bge/bltu/bgeu in the BRANCH state:
  - bne: take = !zero
  - blt: take = negative^overflow
  - bge: take = !(negative^overflow)
  - bltu: take = !carry
  - bgeu: take = carry
  - funct3 010/011 remain illegal.
- Without the macro only beq is legal.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum
  - opcode localparams
  - alu_src_a/alu_src_b/result_src/imm_src encodings
  - ALU control code localparams
- Sub-module: the existing alu_decoder, generalised with ALU_CTRL_W and instantiated inside.
- FSM, imm_src decode and branch-take logic stay in this block.

Test Plan:
- Reset mid-MEMWRITE (reset high 1 cycle) -> next cycle state FETCH; mem_write=0 during reset; no reg_write.
- add x3,x1,x2 (op 0110011, f3 000, f7_5 0), mem_ready=1 -> FETCH, DECODE, EXECR, ALUWB; reg_write=1 only in cycle 4; alu_control=000 in EXECR.
- lw with mem_ready low for 3 cycles in MEMREAD -> FSM holds MEMREAD 4 cycles; reg_write pulses once in MEMWB.
- beq, zero=1 -> pc_write=1 in BRANCH. zero=0 -> pc_write=0. Both return to FETCH.
- op=1111111 -> illegal_instr=1 in DECODE; next state FETCH; no write enables asserted.
- With BRANCH_EXT_EN: blt, negative=1, overflow=0 -> pc_write=1. Without it: same stimulus -> illegal_instr=1, pc_write=0.
